// File: rtl/rr_arb_pkg.sv
// rr_arb_pkg -- shared constants, types and the rotating-priority helper for
// the 4-requester round-robin arbiter (rr_arb4_sel).
//
// Contents:
//   NREQ       number of requesters (fixed at 4, matches the 2-bit mux select)
//   SEL_W      width of the mux select
//   BURST_LEN  max consecutive beats per requester when RR_ARB_BURST_EN is set
//   state_t    arbiter FSM state {IDLE, BUSY}
//   pick_t     {found, idx} result of a priority search
//   next_winner(req, ptr) -> pick_t
//              first set bit of req in the order ptr+1, ptr+2, ptr+3, ptr
package rr_arb_pkg;

  localparam int NREQ      = 4;
  localparam int SEL_W     = 2;
  localparam int BURST_LEN = 4;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  typedef struct packed {
    logic             found;
    logic [SEL_W-1:0] idx;
  } pick_t;

  // The request vector is doubled so that a plain part-select starting just
  // after ptr yields the requests already rotated into search order; the
  // lowest set bit of that window is the winner.
  function automatic pick_t next_winner(input logic [NREQ-1:0]  req,
                                        input logic [SEL_W-1:0] ptr);
    logic [2*NREQ-1:0] dbl;
    logic [NREQ-1:0]   rot;
    int                base;
    pick_t             res;
    dbl  = {req, req};
    base = int'(ptr) + 1;
    rot  = dbl[base +: NREQ];
    res  = '0;
    // Walk from the far end down so the nearest requester is written last.
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        res.found = 1'b1;
        res.idx   = ptr + SEL_W'(k + 1);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// rr_pick4 -- combinational rotating priority encoder.
//
// Ports:
//   req    in  4  request vector
//   ptr    in  2  last-served pointer; search starts at ptr+1 and ends at ptr
//   found  out 1  at least one request is set
//   idx    out 2  winning requester (0 when found=0)
module rr_pick4
  import rr_arb_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic             found,
  output logic [SEL_W-1:0] idx
);

  pick_t pick;

  assign pick  = next_winner(req, ptr);
  assign found = pick.found;
  assign idx   = pick.idx;

endmodule

// File: rtl/rr_arb4_sel.sv
// rr_arb4_sel -- 4-requester round-robin arbiter driving the select of a
// downstream 8-bit 4:1 mux (channels a/b/c/d = req[0..3]).  It owns the
// valid/ready handshake between the four sources and the single sink; the mux
// carries the data.
//
// Ports:
//   clk        in  1  system clock, rising edge
//   rst_n      in  1  asynchronous active-low reset (assert async, release sync)
//   req        in  4  per-source valid, held until the matching in_ready bit
//   in_ready   out 4  per-source accept = grant & {4{out_ready}} (combinational)
//   sel        out 2  registered mux select, 0=a 1=b 2=c 3=d
//   grant      out 4  registered one-hot of sel, zero while idle
//   out_valid  out 1  registered, the mux output holds a valid beat
//   out_ready  in  1  sink accepts the beat this cycle
//
// Build option:
//   RR_ARB_BURST_EN  when defined, a requester that keeps req set is
//                    re-granted for up to BURST_LEN consecutive beats before
//                    the pointer rotates.  Undefined: rotate on every beat.
module rr_arb4_sel
  import rr_arb_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  req,
  output logic [NREQ-1:0]  in_ready,
  output logic [SEL_W-1:0] sel,
  output logic [NREQ-1:0]  grant,
  output logic             out_valid,
  input  logic             out_ready
);

  state_t           state_reg, state_next;
  logic [SEL_W-1:0] sel_reg, sel_next;
  logic [NREQ-1:0]  grant_reg, grant_next;
  logic             valid_reg, valid_next;
  logic [SEL_W-1:0] ptr_reg, ptr_next;

  logic             transfer;
  logic [SEL_W-1:0] pick_ptr;
  logic             win_found;
  logic [SEL_W-1:0] win_idx;

`ifdef RR_ARB_BURST_EN
  localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             burst_hold;
`endif

  assign transfer = valid_reg & out_ready;

  // While busy the search pivots on the channel being served, which is what
  // ptr becomes on the transfer; this lets the winner load in the same cycle
  // as the accepted beat so grants run back-to-back.
  assign pick_ptr = (state_reg == BUSY) ? sel_reg : ptr_reg;

  rr_pick4 u_pick (
    .req   (req),
    .ptr   (pick_ptr),
    .found (win_found),
    .idx   (win_idx)
  );

`ifdef RR_ARB_BURST_EN
  assign burst_hold = req[sel_reg] && (cnt_reg < CNT_W'(BURST_LEN - 1));
`endif

  always_comb begin
    state_next = state_reg;
    sel_next   = sel_reg;
    grant_next = grant_reg;
    valid_next = valid_reg;
    ptr_next   = ptr_reg;
`ifdef RR_ARB_BURST_EN
    cnt_next   = cnt_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (win_found) begin
          sel_next   = win_idx;
          grant_next = NREQ'(1) << win_idx;
          valid_next = 1'b1;
          state_next = BUSY;
`ifdef RR_ARB_BURST_EN
          cnt_next   = '0;
`endif
        end
      end
      BUSY: begin
        // Select and grant are frozen during a stall; only a completed beat
        // may move them.
        if (transfer) begin
`ifdef RR_ARB_BURST_EN
          if (burst_hold) begin
            cnt_next = cnt_reg + CNT_W'(1);
          end else begin
            cnt_next = '0;
`endif
            ptr_next = sel_reg;
            if (win_found) begin
              sel_next   = win_idx;
              grant_next = NREQ'(1) << win_idx;
            end else begin
              grant_next = '0;
              valid_next = 1'b0;
              state_next = IDLE;
            end
`ifdef RR_ARB_BURST_EN
          end
`endif
        end
      end
      default: begin
        state_next = IDLE;
        grant_next = '0;
        valid_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      sel_reg   <= '0;
      grant_reg <= '0;
      valid_reg <= 1'b0;
      // Pointer starts at the last channel so channel 0 wins first.
      ptr_reg   <= SEL_W'(NREQ - 1);
`ifdef RR_ARB_BURST_EN
      cnt_reg   <= '0;
`endif
    end else begin
      state_reg <= state_next;
      sel_reg   <= sel_next;
      grant_reg <= grant_next;
      valid_reg <= valid_next;
      ptr_reg   <= ptr_next;
`ifdef RR_ARB_BURST_EN
      cnt_reg   <= cnt_next;
`endif
    end
  end

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
      assign in_ready[gi] = grant_reg[gi] & out_ready;
    end
  endgenerate

  assign sel       = sel_reg;
  assign grant     = grant_reg;
  assign out_valid = valid_reg;

endmodule
